// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter, one frame at a time.
// Optional per-byte watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [1:0]           parity_type,
    input  logic [1:0]           baud_rate,
    input  logic                 active_flag,
    input  logic                 done_flag,
    output logic                 send,
    output logic [7:0]           data_in,
    output logic [1:0]           tx_parity_type,
    output logic [1:0]           tx_baud_rate,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_idx;
    logic             any_req;
    logic             done_prev;
    logic             done_rise;
    logic             abort;
    logic [7:0]       req_bytes [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_bytes[k] = req_data[8*k +: 8];
        end
    end

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        any_req = 1'b0;
        winner  = last_winner;
        rr_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = IDX_W'((int'(last_winner) + k) % NUM_REQ);
            if (!any_req && req[rr_idx]) begin
                any_req = 1'b1;
                winner  = rr_idx;
            end
        end
    end

    assign done_rise = done_flag & ~done_prev;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cycle_cnt;
    logic             cnt_hit;

    assign cnt_hit = (cycle_cnt + 1'b1) == CNT_W'(TIMEOUT_CYCLES);
    assign abort   = cnt_hit && (((state == START) && !active_flag) ||
                                 ((state == WAIT_DONE) && !done_rise));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state == IDLE && any_req) begin
                cycle_cnt <= '0;
            end else if (state == START || state == WAIT_DONE) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next = state;
        send       = (state == START);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) state_next = START;
            end
            START: begin
                if (active_flag)  state_next = WAIT_DONE;
                else if (abort)   state_next = RELEASE;
            end
            WAIT_DONE: begin
                if (done_rise || abort) state_next = RELEASE;
            end
            RELEASE: begin
                if (!active_flag && !done_flag) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame settings are captured once at grant and held for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_winner    <= IDX_W'(NUM_REQ - 1);
            gnt            <= '0;
            ack            <= '0;
            data_in        <= 8'h00;
            tx_parity_type <= 2'b00;
            tx_baud_rate   <= 2'b00;
            done_prev      <= 1'b0;
        end else begin
            state     <= state_next;
            done_prev <= done_flag;
            ack       <= '0;
            if (state == IDLE && any_req) begin
                last_winner    <= winner;
                gnt            <= NUM_REQ'(1) << winner;
                data_in        <= req_bytes[winner];
                tx_parity_type <= parity_type;
                tx_baud_rate   <= baud_rate;
            end
            if (state == WAIT_DONE && done_rise) begin
                ack <= gnt;
            end
            if (state == RELEASE && state_next == IDLE) begin
                gnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, hand-written corner cases and
// randomized frames against a round-robin reference model.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 50;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int DONE_LONG = 40;
`else
    localparam int DONE_LONG = 100;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_data;
    logic [1:0]    parity_type;
    logic [1:0]    baud_rate;
    logic          active_flag;
    logic          done_flag;
    logic          send;
    logic [7:0]    data_in;
    logic [1:0]    tx_parity_type;
    logic [1:0]    tx_baud_rate;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          busy;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;
    int model_lw;
    logic [3:0] got_gnt;
    logic [7:0] got_data;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_data       (req_data),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .active_flag    (active_flag),
        .done_flag      (done_flag),
        .send           (send),
        .data_in        (data_in),
        .tx_parity_type (tx_parity_type),
        .tx_baud_rate   (tx_baud_rate),
        .gnt            (gnt),
        .ack            (ack),
        .busy           (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

`ifndef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic [1:0] p, input logic [1:0] b);
        req         = r;
        req_data    = d;
        parity_type = p;
        baud_rate   = b;
    endtask

    // Reference arbitration rule: first requesting index after the last winner, wrapping around.
    function automatic int model_winner(input logic [3:0] r, input int lw);
        int pos;
        for (int k = 1; k <= N; k++) begin
            pos = (lw + k) % N;
            if (((r >> pos) & 4'd1) != 4'd0) return pos;
        end
        return 0;
    endfunction

    // Called at an idle negedge; runs one whole frame with a modelled transmitter.
    task automatic full_frame(input string tag, input logic [3:0] r, input bit drive,
                              input int act_d, input int done_d, input bit pre_done,
                              input int drop_at, input bit hold, input bit exp_to);
        int w, c, send_cycles, ack_cycles, ack_at, to_pulses;
        logic [3:0] exp_gnt, ack_val;
        logic [7:0] exp_data;
        logic [1:0] exp_p, exp_b;
        bit stable;
        if (drive) req = r;
        w        = model_winner(req, model_lw);
        exp_gnt  = 4'b0001 << w;
        exp_data = 8'(req_data >> (8 * w));
        exp_p    = parity_type;
        exp_b    = baud_rate;
        model_lw = w;
        @(negedge clk);
        got_gnt  = gnt;
        got_data = data_in;
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        checkOutput({tag, ".onehot"}, 32'($onehot(gnt)), 32'd1);
        checkOutput({tag, ".send_rise"}, 32'(send), 32'd1);
        checkOutput({tag, ".data_in"}, 32'(data_in), 32'(exp_data));
        checkOutput({tag, ".parity"}, 32'(tx_parity_type), 32'(exp_p));
        checkOutput({tag, ".baud"}, 32'(tx_baud_rate), 32'(exp_b));
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
        c = 1; send_cycles = 0; ack_cycles = 0; ack_at = -1; to_pulses = 0;
        ack_val = '0; stable = 1'b1;
        while (busy === 1'b1 && c < 400) begin
            if (send) send_cycles++;
            if (timeout_err) to_pulses++;
            if (gnt !== exp_gnt || data_in !== exp_data || tx_parity_type !== exp_p || tx_baud_rate !== exp_b)
                stable = 1'b0;
            if (ack != '0) begin
                ack_cycles++;
                ack_at  = c;
                ack_val = ack;
                if (!hold) req = req & ~ack;
            end
            if (c == drop_at) req = '0;
            if (c == 3) begin
                parity_type = ~parity_type;
                baud_rate   = ~baud_rate;
            end
            active_flag = (c >= act_d) && (c < done_d);
            done_flag   = (c >= done_d && c < done_d + 2) || (pre_done && c >= act_d && c < act_d + 4);
            @(negedge clk);
            c++;
        end
        active_flag = 1'b0;
        done_flag   = 1'b0;
        if (exp_to) begin
            checkOutput({tag, ".send_cycles"}, 32'(send_cycles), 32'(TO));
            checkOutput({tag, ".ack_count"}, 32'(ack_cycles), 32'd0);
            checkOutput({tag, ".timeout_pulses"}, 32'(to_pulses), 32'd1);
        end else begin
            checkOutput({tag, ".send_cycles"}, 32'(send_cycles), 32'(act_d));
            checkOutput({tag, ".ack_count"}, 32'(ack_cycles), 32'd1);
            checkOutput({tag, ".ack_cycle"}, 32'(ack_at), 32'(done_d + 1));
            checkOutput({tag, ".ack_value"}, 32'(ack_val), 32'(exp_gnt));
            checkOutput({tag, ".timeout_pulses"}, 32'(to_pulses), 32'd0);
        end
        checkOutput({tag, ".stable"}, 32'(stable), 32'd1);
        checkOutput({tag, ".idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".idle_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, ".idle_send"}, 32'(send), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b1010, 32'hD4C3B2A1, 4'b0010, 8'hB2};
        vecs[1] = '{4'b0101, 32'h0F1E2D3C, 4'b0100, 8'h1E};
        vecs[2] = '{4'b0011, 32'h89ABCDEF, 4'b0001, 8'hEF};
        vecs[3] = '{4'b1001, 32'h5A6B7C8D, 4'b1000, 8'h5A};
        vecs[4] = '{4'b0110, 32'h01234567, 4'b0010, 8'h45};
        vecs[5] = '{4'b0010, 32'hFFEEDDCC, 4'b0010, 8'hDD};
        vecs[6] = '{4'b1100, 32'h13579BDF, 4'b0100, 8'h57};
        vecs[7] = '{4'b1111, 32'h2468ACE0, 4'b1000, 8'h24};
        vecs[8] = '{4'b0001, 32'h7E7E7E00, 4'b0001, 8'h00};

        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0, 2'b00, 2'b00);
        active_flag = 1'b0;
        done_flag   = 1'b0;
        model_lw    = N - 1;
        #12;
        checkOutput("reset.send", 32'(send), 32'd0);
        checkOutput("reset.data_in", 32'(data_in), 32'd0);
        checkOutput("reset.parity", 32'(tx_parity_type), 32'd0);
        checkOutput("reset.baud", 32'(tx_baud_rate), 32'd0);
        checkOutput("reset.gnt", 32'(gnt), 32'd0);
        checkOutput("reset.ack", 32'(ack), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four requesters held high: grant order 0,1,2,3,0.
        applyStimulus(4'b1111, 32'h44332211, 2'b01, 2'b10);
        for (int i = 0; i < 5; i++) begin
            full_frame($sformatf("rr%0d", i), 4'b1111, 1'b0, 2, 6, 1'b0, -1, 1'b1, 1'b0);
            checkOutput($sformatf("rr%0d.order", i), 32'(got_gnt), 32'(4'b0001 << (i % 4)));
        end

        applyStimulus(4'b0001, 32'h000000A5, 2'b10, 2'b01);
        full_frame("single", 4'b0001, 1'b0, 10, DONE_LONG, 1'b0, -1, 1'b0, 1'b0);
        checkOutput("single.byte", 32'(got_data), 32'h0A5);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].data, 2'(i), 2'(3 - i));
            full_frame($sformatf("vec%0d", i), vecs[i].req, 1'b0, 1 + i % 4, 5 + i % 4 + i, 1'b0, -1, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d.tbl_gnt", i), 32'(got_gnt), 32'(vecs[i].exp_gnt));
            checkOutput($sformatf("vec%0d.tbl_data", i), 32'(got_data), 32'(vecs[i].exp_data));
        end

        applyStimulus(4'b0100, 32'h00C30000, 2'b11, 2'b11);
        full_frame("predone", 4'b0100, 1'b0, 4, 20, 1'b1, -1, 1'b0, 1'b0);

        applyStimulus(4'b0010, 32'h00005C00, 2'b00, 2'b01);
        full_frame("dropreq", 4'b0010, 1'b0, 3, 15, 1'b0, 5, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int a;
            a = $urandom_range(1, 8);
            applyStimulus(4'($urandom_range(1, 15)), $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            full_frame($sformatf("rand%0d", i), req, 1'b0, a, a + $urandom_range(3, 20), 1'b0, -1, 1'b0, 1'b0);
        end

        // Reset while requester 2 waits for done_flag.
        applyStimulus(4'b0100, 32'hCAFEBABE, 2'b01, 2'b10);
        @(negedge clk);
        checkOutput("midrst.gnt", 32'(gnt), 32'h4);
        active_flag = 1'b1;
        @(negedge clk);
        checkOutput("midrst.waiting", 32'(send), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        active_flag = 1'b0;
        #1;
        checkOutput("midrst.send", 32'(send), 32'd0);
        checkOutput("midrst.data_in", 32'(data_in), 32'd0);
        checkOutput("midrst.parity", 32'(tx_parity_type), 32'd0);
        checkOutput("midrst.baud", 32'(tx_baud_rate), 32'd0);
        checkOutput("midrst.gnt", 32'(gnt), 32'd0);
        checkOutput("midrst.ack", 32'(ack), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_lw = N - 1;
        applyStimulus(4'b0110, 32'h11223344, 2'b11, 2'b00);
        full_frame("afterrst", 4'b0110, 1'b0, 3, 12, 1'b0, -1, 1'b0, 1'b0);
        checkOutput("afterrst.lowest", 32'(got_gnt), 32'h2);

`ifdef UART_TX_ARB_TIMEOUT_EN
        applyStimulus(4'b0010, 32'h00007700, 2'b01, 2'b01);
        full_frame("timeout", 4'b0010, 1'b0, 10000, 20000, 1'b0, -1, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, clk cycles allowed per byte before abort.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  NUM_REQ  per-requester level request; held high until that requester's ack pulse.
REQ-006 req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i] is high.
REQ-007 parity_type  input  2  parity mode passed to the transmitter.
REQ-008 baud_rate  input  2  baud rate select passed to the transmitter.
REQ-009 active_flag  input  1  transmitter frame-in-progress level.
REQ-010 done_flag  input  1  transmitter frame-complete level.
REQ-011 send  output  1  transmitter start request.
REQ-012 data_in  output  8  byte presented to the transmitter.
REQ-013 tx_parity_type  output  2  registered parity mode for the current frame.
REQ-014 tx_baud_rate  output  2  registered baud select for the current frame.
REQ-015 gnt  output  NUM_REQ  one-hot owner of the transmitter, all zero when idle.
REQ-016 ack  output  NUM_REQ  one-cycle pulse on the owner's bit when its byte completes.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, START, WAIT_DONE, RELEASE.
REQ-019 IDLE: if any req bit is high, grant by round-robin starting at (last_winner+1) mod NUM_REQ.
REQ-020 IDLE: on grant, latch data_in, tx_parity_type and tx_baud_rate, set gnt, then go to START.
REQ-021 START: drive send=1 until active_flag is sampled high, then go to WAIT_DONE with send=0 on the next cycle.
REQ-022 WAIT_DONE: detect a rising edge of done_flag (registered previous value 0, current 1), pulse ack for the owner, then go to RELEASE.
REQ-023 RELEASE: wait until active_flag=0 and done_flag=0, then clear gnt and return to IDLE.
REQ-024 Grant latency: gnt is set and send rises on the 1st clk edge after req is sampled in IDLE.
REQ-025 If req drops while owned, the frame still completes and ack still pulses.
REQ-026 Requests arriving in any state except IDLE wait; at most one frame is in flight.
REQ-027 data_in, tx_parity_type and tx_baud_rate hold constant from grant until return to IDLE.
REQ-028 last_winner updates only on grant, and is NUM_REQ-1 after reset so requester 0 wins first.
REQ-029 Simultaneous requests never produce more than one gnt bit.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, send=0, data_in=0, tx_parity_type=0, tx_baud_rate=0, gnt=0, ack=0, busy=0, timeout_err=0, done_flag history=0.
REQ-031 Reset mid-frame abandons the frame with no ack; the transmitter is reset by the same rst_n.

Configuration
REQ-032 Macro UART_TX_ARB_TIMEOUT_EN.
REQ-033 When defined: add output timeout_err (1 bit) and a cycle counter cleared on grant.
REQ-034 When defined, if the counter reaches TIMEOUT_CYCLES in START or WAIT_DONE: drop send, pulse timeout_err for one cycle, give no ack, and go to RELEASE.
REQ-035 When undefined: no counter and no timeout_err port; START and WAIT_DONE wait indefinitely.

Verification
REQ-036 req=4'b0001, req_data[7:0]=8'hA5, model active_flag 10 cycles later and done_flag 100 cycles later -> data_in=8'hA5, send high 10 cycles, ack=4'b0001 for one cycle, busy low after release.
REQ-037 req=4'b1111 held high -> grant order 0,1,2,3,0, and gnt is always one-hot.
REQ-038 done_flag already high on entry to WAIT_DONE -> no ack until done_flag falls and rises again.
REQ-039 rst_n low during WAIT_DONE of requester 2 -> all outputs 0 immediately; the next grant after reset goes to the lowest-indexed active requester.
REQ-040 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, active_flag never asserted -> send drops at cycle 50, timeout_err pulses once, no ack, and the arbiter returns to IDLE.
REQ-041 req[1] released mid-frame -> ack[1] still pulses at the done_flag rising edge.
